mod8_counter: RTL and testbench
===============================

// Module: mod8_counter
//
// PURPOSE
//   Free-running modulo-8 up-counter; 3-bit binary count advancing once per clock.
//   Used as a small sequencing/timebase primitive (phase index, 8-slot scheduler tick).
//   Counts 0..7 and wraps to 0. Only control is a synchronous reset; no enable, no load.
//
// PARAMETERS
//   MODULUS  8  number of states; count sequence is 0..MODULUS-1 (must be >= 2)
//   WIDTH    3  width of count; must satisfy 2**WIDTH >= MODULUS (checked at elaboration)
//
// PORTS
//   clk    in   1      single clock; all state updates on rising edge
//   rst    in   1      synchronous, active-high reset; sampled only at rising clk
//   count  out  WIDTH  current count value, registered output
//   Port order is fixed as (clk, rst, count); positional instantiation is supported.
//
// BEHAVIOUR
//   - One clock domain; synchronous, active-high reset; no asynchronous paths.
//   - At each rising clk:
//       rst==1                 -> count <= 0
//       rst==0, count==MOD-1   -> count <= 0 (wrap)
//       rst==0, otherwise      -> count <= count + 1
//   - Reset value of count: 0. Before the first clk edge with rst==1, count is undefined.
//     No initial blocks for functional state.
//   - Latency: count changes only on a rising clk; it reflects the update one edge after the
//     inputs are sampled. No combinational path from rst to count.
//   - Reset wins over increment and wrap on the same edge.
//   - Mid-sequence reset (any count value) returns count to 0 on that edge. The next non-reset
//     edge gives 1.
//   - Reset held for N edges keeps count at 0 for all N edges.
//   - Default MODULUS=8, WIDTH=3: wrap coincides with natural 3-bit overflow. Non-power-of-two
//     MODULUS must use an explicit terminal-count compare, not overflow.
//   - Out-of-range state (count >= MODULUS, e.g. after X or an upset) -> next non-reset edge
//     forces count to 0.
//   - Full period without reset = MODULUS clocks.
//
// STRUCTURE
//   - Shared package cnt_pkg: default MODULUS/WIDTH constants and a
//     function clog2_min(modulus) for width checking.
//   - Natural sub-module: mod_n_counter (generic WIDTH/MODULUS register + terminal-count compare).
//     mod8_counter instantiates it with MODULUS=8, WIDTH=3.
//   - Elaboration assertions: MODULUS>=2, 2**WIDTH>=MODULUS.
//
// TESTING
//   (Clock period 10, first rising edge at t=5.)
//   1. rst=1 for first edge (t=5) -> count=000 after that edge.
//   2. rst=0 for 8 edges (t=15..85) -> count=1,2,3,4,5,6,7,0 (wrap 111->000 at t=85).
//   3. rst=1 at count=000 for one edge (t=95) -> count stays 000.
//   4. rst=0 for 4 edges (t=105..135) -> count=1,2,3,4.
//   5. rst asserted at count=5 -> next edge count=0; rst held 3 edges -> 0,0,0.
//      Release rst -> 1.
//   6. Run 24 edges free -> exactly 3 wraps; count never exceeds 7.
//      Parameter sweep MODULUS=5, WIDTH=3 -> sequence 0..4,0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and width helper for the modulo-N counter family.
package cnt_pkg;

   localparam int DEF_MODULUS = 8;
   localparam int DEF_WIDTH   = 3;

   // Smallest width (at least 1) whose binary range covers 0..modulus-1.
   function automatic int clog2_min(input int modulus);
      int w;
      w = 1;
      while ((1 << w) < modulus) w++;
      return w;
   endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Generic modulo-N up-counter: register plus terminal-count compare.
module mod_n_counter
   import cnt_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS,
   parameter int WIDTH   = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count
);

   if (MODULUS < 2) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS must be >= 2");
   end
   if (WIDTH < clog2_min(MODULUS)) begin : g_bad_width
      $error("mod_n_counter: WIDTH too small for MODULUS");
   end

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;
   logic             w_term;

   // >= rather than == so an out-of-range state recovers to 0 on the next edge.
   assign w_term = (r_count >= TERM);

   always_ff @(posedge clk) begin
      if (rst)         r_count <= '0;
      else if (w_term) r_count <= '0;
      else             r_count <= r_count + WIDTH'(1);
   end

   assign count = r_count;

endmodule

// File: rtl/mod8_counter.sv
// Free-running modulo-8 counter; thin wrapper over mod_n_counter.
module mod8_counter
   import cnt_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS,
   parameter int WIDTH   = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] w_count;

   mod_n_counter #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .count (w_count)
   );

   assign count = w_count;

endmodule

// File: tb/tb_mod8_counter.sv
// Self-checking bench for mod8_counter (default and MODULUS=5 instances).
module tb_mod8_counter;

   logic       clk;
   logic       rst;
   logic [2:0] count8;
   logic [2:0] count5;

   int errors;
   int checks;
   int m8;
   int m5;
   int wraps8;

   mod8_counter u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .count (count8)
   );

   mod8_counter #(.MODULUS(5), .WIDTH(3)) u_dut5 (
      .clk   (clk),
      .rst   (rst),
      .count (count5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one edge and advance the reference models.
   task automatic tick(input logic r);
      rst = r;
      @(posedge clk);
      #1;
      if (r) begin
         m8 = 0;
         m5 = 0;
      end else begin
         if (m8 == 7) wraps8++;
         m8 = (m8 + 1) % 8;
         m5 = (m5 + 1) % 5;
      end
   endtask

   task automatic test_reset();
      tick(1'b1);
      checks++;
      if (count8 !== 3'd0) begin
         errors++;
         $display("FAIL reset8: got %0d want 0", count8);
      end
      checks++;
      if (count5 !== 3'd0) begin
         errors++;
         $display("FAIL reset5: got %0d want 0", count5);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 8; i++) begin
         tick(1'b0);
         checks++;
         if (count8 !== 3'((i + 1) % 8)) begin
            errors++;
            $display("FAIL wrap[%0d]: got %0d want %0d", i, count8, (i + 1) % 8);
         end
      end
   endtask

   task automatic test_reset_at_zero();
      tick(1'b1);
      checks++;
      if (count8 !== 3'd0) begin
         errors++;
         $display("FAIL reset_at_zero: got %0d want 0", count8);
      end
      for (int i = 1; i <= 4; i++) begin
         tick(1'b0);
         checks++;
         if (count8 !== 3'(i)) begin
            errors++;
            $display("FAIL count_after_reset[%0d]: got %0d want %0d", i, count8, i);
         end
      end
   endtask

   task automatic test_mid_reset();
      tick(1'b0);
      checks++;
      if (count8 !== 3'd5) begin
         errors++;
         $display("FAIL mid_pre: got %0d want 5", count8);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         checks++;
         if (count8 !== 3'd0) begin
            errors++;
            $display("FAIL mid_hold[%0d]: got %0d want 0", i, count8);
         end
      end
      tick(1'b0);
      checks++;
      if (count8 !== 3'd1) begin
         errors++;
         $display("FAIL mid_release: got %0d want 1", count8);
      end
   endtask

   task automatic test_free_run();
      int max_seen;
      int w0;
      max_seen = 0;
      w0 = wraps8;
      for (int i = 0; i < 24; i++) begin
         tick(1'b0);
         if (int'(count8) > max_seen) max_seen = int'(count8);
         checks++;
         if (count8 !== 3'(m8)) begin
            errors++;
            $display("FAIL free[%0d]: got %0d want %0d", i, count8, m8);
         end
      end
      checks++;
      if ((wraps8 - w0) != 3 || max_seen != 7) begin
         errors++;
         $display("FAIL free_wraps: wraps=%0d max=%0d want 3 and 7", wraps8 - w0, max_seen);
      end
   endtask

   task automatic test_mod5();
      tick(1'b1);
      for (int i = 1; i <= 6; i++) begin
         tick(1'b0);
         checks++;
         if (count5 !== 3'(i % 5)) begin
            errors++;
            $display("FAIL mod5[%0d]: got %0d want %0d", i, count5, i % 5);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         tick(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
         checks++;
         if (count8 !== 3'(m8)) begin
            errors++;
            $display("FAIL rand8[%0d]: got %0d want %0d", i, count8, m8);
         end
         checks++;
         if (count5 !== 3'(m5)) begin
            errors++;
            $display("FAIL rand5[%0d]: got %0d want %0d", i, count5, m5);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      m8     = 0;
      m5     = 0;
      wraps8 = 0;
      rst    = 1'b1;
      test_reset();
      test_wrap();
      test_reset_at_zero();
      test_mid_reset();
      test_free_run();
      test_mod5();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
